// File: rtl/exec_if.sv
// Control-word and memory-side bundle between the control unit and the execution unit.
// The control unit drives the control word; the datapath returns memory address/data, IR and status.
interface exec_if #(
  parameter int DW = 16
) ();
  logic [2:0]    W_Adr;
  logic [2:0]    R_Adr;
  logic [2:0]    S_Adr;
  logic          adr_sel;
  logic          s_sel;
  logic          pc_ld;
  logic          pc_inc;
  logic          pc_sel;
  logic          ir_ld;
  logic          rw_en;
  logic [3:0]    alu_op;
  logic [DW-1:0] D_in;
  logic [DW-1:0] Address;
  logic [DW-1:0] D_out;
  logic [DW-1:0] IR;
  logic          N;
  logic          Z;
  logic          C;

  modport master (
    output W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
           ir_ld, rw_en, alu_op, D_in,
    input  Address, D_out, IR, N, Z, C
  );

  modport slave (
    input  W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
           ir_ld, rw_en, alu_op, D_in,
    output Address, D_out, IR, N, Z, C
  );
endinterface

// File: rtl/exec_unit.sv
// Execution unit: 8x16 register file, PC, IR and ALU, steered one control word per clock.
// Status flags and memory address/data are combinational from the current state and control word.
module exec_unit #(
  parameter int          DW     = 16,
  parameter logic [15:0] PC_RST = 16'h0000
) (
  input logic    clk,
  input logic    reset,
  exec_if.slave  bus
);

  logic [DW-1:0]        rf [8];
  logic [DW-1:0]        pc_q;
  logic [DW-1:0]        ir_q;
  logic [DW-1:0]        r_port;
  logic [DW-1:0]        s_port;
  logic [DW:0]          alu_res;
  logic [DW-1:0]        y;
  logic [DW-1:0]        wr_data;
  logic signed [DW-1:0] br_off;

  // Bit DW of the result carries the carry/borrow; 17-bit math gives both for free.
  function automatic logic [DW:0] alu_f(input logic [3:0] op,
                                        input logic [DW-1:0] r,
                                        input logic [DW-1:0] s);
    logic [DW:0] res;
    case (op)
      4'b0000: res = {1'b0, s};
      4'b0001: res = {1'b0, r};
      4'b0010: res = {1'b0, s} + {{DW{1'b0}}, 1'b1};
      4'b0011: res = {1'b0, s} - {{DW{1'b0}}, 1'b1};
      4'b0100: res = {1'b0, r} + {1'b0, s};
      4'b0101: res = {1'b0, r} - {1'b0, s};
      4'b0110: res = {s[0], 1'b0, s[DW-1:1]};
      4'b0111: res = {s[DW-1], s[DW-2:0], 1'b0};
      default: res = '0;
    endcase
    return res;
  endfunction

  assign r_port  = rf[bus.R_Adr];
  assign s_port  = rf[bus.S_Adr];
  assign alu_res = alu_f(bus.alu_op, r_port, s_port);
  assign y       = alu_res[DW-1:0];
  assign wr_data = bus.s_sel ? bus.D_in : y;
  assign br_off  = {{(DW-8){ir_q[7]}}, ir_q[7:0]};

  assign bus.Address = bus.adr_sel ? r_port : pc_q;
  assign bus.D_out   = s_port;
  assign bus.IR      = ir_q;
  assign bus.N       = y[DW-1];
  assign bus.Z       = (y == '0);
  assign bus.C       = alu_res[DW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (bus.rw_en) begin
      rf[bus.W_Adr] <= wr_data;
    end
  end

  // A load beats an increment; relative branches use the PC held before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= PC_RST;
    end else if (bus.pc_ld) begin
      pc_q <= bus.pc_sel ? r_port : pc_q + $unsigned(br_off);
    end else if (bus.pc_inc) begin
      pc_q <= pc_q + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
    end else if (bus.ir_ld) begin
      ir_q <= bus.D_in;
    end
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Datapath responder to the control unit's control word. Holds the 8x16 register file, 16-bit PC and IR, and the ALU.
- Drives the memory address and write data. Returns IR and the combinational N/Z/C status to the control unit.
- Sits between the control unit and the 256x16 memory. The control unit's mw_en goes directly to memory, not through this block.

Parameters:
- DW, 16, datapath/register/PC/IR width; only 16 is supported.
- PC_RST, 16'h0000, PC value after reset.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- W_Adr  in  3  register file write address
- R_Adr  in  3  register file R-port read address
- S_Adr  in  3  register file S-port read address
- adr_sel  in  1  0: Address=PC; 1: Address=R-port
- s_sel  in  1  0: reg write data=ALU result; 1: reg write data=D_in
- pc_ld  in  1  load PC
- pc_inc  in  1  increment PC
- pc_sel  in  1  PC load source; 0: PC+sext(IR[7:0]); 1: R-port
- ir_ld  in  1  IR <= D_in
- rw_en  in  1  register file write enable
- alu_op  in  4  ALU operation
- D_in  in  16  memory read data
- Address  out  16  memory address; memory uses [7:0]
- D_out  out  16  memory write data = S-port
- IR  out  16  instruction register
- N  out  1  ALU result bit 15, combinational
- Z  out  1  ALU result == 0, combinational
- C  out  1  ALU carry/borrow, combinational

Behaviour:
- Reset (async, immediate):
  - R0-R7=0, PC=PC_RST, IR=0.
  - Address=PC_RST (adr_sel=0), D_out=0.
  - N/Z/C follow the ALU on zeroed registers.
- Register file reads are combinational. R-port=R[R_Adr], S-port=R[S_Adr]. R0 is an ordinary register.
- Register write on rising edge when rw_en=1: R[W_Adr] <= s_sel ? D_in : Y.
  - Read of the same address in the same cycle returns the old value; the new value is visible the next cycle.
- ALU, combinational, 17-bit internal. Y=result[15:0].
  - 0000 Y=S, C=0
  - 0001 Y=R, C=0
  - 0010 Y=S+1, C=carry out
  - 0011 Y=S-1, C=borrow (S==0)
  - 0100 Y=R+S, C=carry out
  - 0101 Y=R-S, C=borrow (R<S unsigned)
  - 0110 Y=S>>1 logical, C=S[0]
  - 0111 Y=S<<1, C=S[15]
  - 1000-1111: Y=0, C=0 (reserved)
  - N=Y[15], Z=(Y==16'h0000) for all ops.
- PC update on rising edge:
  - pc_ld=1, pc_sel=0: PC <= PC + {{8{IR[7]}},IR[7:0]}, using the PC value before this edge.
  - pc_ld=1, pc_sel=1: PC <= R-port.
  - pc_ld=0, pc_inc=1: PC <= PC+1.
  - pc_ld has priority over pc_inc when both are asserted.
  - 16-bit wrap: FFFF+1=0000; PC+sext wraps modulo 2^16.
- IR <= D_in on rising edge when ir_ld=1, independent of PC update.
  - Jump states assert ir_ld. IR then captures M[PC] at the pre-jump PC; the following FETCH overwrites it. No special handling.
- Address = adr_sel ? R-port : PC, combinational. D_out = S-port, combinational.
- Single-cycle latency: each control word fully takes effect at the next rising edge. No internal state machine beyond PC/IR/register file sequencing. No handshake; memory reads are combinational within the cycle.
- Reset asserted mid-instruction: all state clears immediately; any pending register or PC write in that cycle is discarded.

Test Plan:
- Reset pulse mid-run with R3=1234, PC=0042 -> R3=0, PC=0000, IR=0, Address=0000 immediately, before any clock edge.
- Fetch: PC=0005, adr_sel=0, D_in=E0CA, ir_ld=1, pc_inc=1 -> after edge IR=E0CA, PC=0006; with PC=FFFF, pc_inc -> PC=0000.
- ADD carry: R1=FFFF, R2=0001, alu_op=0100, R_Adr=1, S_Adr=2, W_Adr=3, rw_en=1 -> pre-edge N=0, Z=1, C=1; after edge R3=0000.
- SUB borrow: R1=0003, R2=0005, alu_op=0101 -> Y=FFFE, N=1, Z=0, C=1. SHR S=0003 -> Y=0001, C=1.
- LD/STO: R2=0010, adr_sel=1, R_Adr=2 -> Address=0010; s_sel=1, D_in=BEEF, W_Adr=4, rw_en=1 -> R4=BEEF. S_Adr=4 -> D_out=BEEF.
- Branches: PC=0020, IR[7:0]=F8, pc_ld=1, pc_sel=0 -> PC=0018. R5=0077, pc_sel=1, R_Adr=5, pc_ld=1 with pc_inc=1 -> PC=0077 (load wins).
